// File: rtl/sr_latch_sequencer.sv
// Round-robin owner of one cross-coupled NAND set/reset latch: issues active-low
// set/reset pulses with recovery gaps, confirms each operation by readback, acks requesters.
module sr_latch_sequencer #(
  parameter int N_REQ   = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int IDW     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op,
  output logic [N_REQ-1:0] ack,
  output logic             s_n,
  output logic             r_n,
  input  logic             q_in,
  output logic             busy,
  output logic             err,
  output logic [IDW-1:0]   err_id,
  input  logic             err_clr
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PULSE, S_RECOVER, S_CHECK, S_ACK
  } state_t;

  localparam logic [3:0]     PW_LAST  = 4'(PULSE_W - 1);
  localparam logic [3:0]     GW_LAST  = 4'(GAP_W - 1);
  localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic             op_q, op_d;
  logic             from_init_q, from_init_d;
  logic             s_n_q, s_n_d, r_n_q, r_n_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic [IDW-1:0]   err_id_q, err_id_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             found;
  logic [IDW-1:0]   pick;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  // First requesting index strictly after the last grant, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && req[rr_idx(last_q, i)]) begin
        found = 1'b1;
        pick  = rr_idx(last_q, i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    grant_d     = grant_q;
    op_d        = op_q;
    from_init_d = from_init_q;
    err_d       = err_q;
    err_id_d    = err_id_q;
    if (err_clr) err_d = 1'b0;

    case (state_q)
      S_INIT: begin
        if (cnt_q == PW_LAST) begin
          state_d     = S_RECOVER;
          cnt_d       = '0;
          from_init_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_IDLE: begin
        // ack_q still high means the acked requester has not yet had a chance to drop req.
        if (found && ack_q == '0) begin
          grant_d = pick;
          op_d    = op[pick];
          cnt_d   = '0;
          state_d = (q_in == op[pick]) ? S_ACK : S_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt_q == PW_LAST) begin
          state_d     = S_RECOVER;
          cnt_d       = '0;
          from_init_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RECOVER: begin
        if (cnt_q == GW_LAST) begin
          state_d = from_init_q ? S_IDLE : S_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (q_in != op_q) begin
          err_d    = 1'b1;
          err_id_d = grant_q;
        end
        state_d = S_ACK;
      end
      S_ACK: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase

    // Drives follow the current state one cycle late; s_n and r_n are never both low.
    s_n_d  = !(state_q == S_PULSE && op_q);
    r_n_d  = !((state_q == S_PULSE && !op_q) || state_q == S_INIT);
    ack_d  = '0;
    if (state_q == S_ACK) ack_d[grant_q] = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      last_q      <= LAST_RST;
      from_init_q <= 1'b1;
      s_n_q       <= 1'b1;
      r_n_q       <= 1'b1;
      busy_q      <= 1'b1;
      err_q       <= 1'b0;
      err_id_q    <= '0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      from_init_q <= from_init_d;
      s_n_q       <= s_n_d;
      r_n_q       <= r_n_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      err_id_q    <= err_id_d;
      ack_q       <= ack_d;
    end
  end

  always_ff @(posedge clk) begin
    grant_q <= grant_d;
    op_q    <= op_d;
  end

  assign ack    = ack_q;
  assign s_n    = s_n_q;
  assign r_n    = r_n_q;
  assign busy   = busy_q;
  assign err    = err_q;
  assign err_id = err_id_q;

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Bench for sr_latch_sequencer: NAND latch model on s_n/r_n, transaction-level
// round-robin reference with timing formulas, randomized request rounds.
module tb_sr_latch_sequencer;

  localparam int N   = 4;
  localparam int PW  = 2;
  localparam int GW  = 1;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   op = '0;
  logic [N-1:0]   ack;
  logic           s_n, r_n;
  logic           q_in;
  logic           busy, err;
  logic [IDW-1:0] err_id;
  logic           err_clr = 1'b0;

  logic lq = 1'b1;
  logic stuck = 1'b0;
  int   viol = 0;

  int   total = 0;
  int   bad = 0;

  int   m_ptr = N - 1;
  logic m_q = 1'b0;
  logic exp_err = 1'b0;
  int   exp_id = 0;

  sr_latch_sequencer #(.N_REQ(N), .PULSE_W(PW), .GAP_W(GW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .ack(ack),
    .s_n(s_n), .r_n(r_n), .q_in(q_in), .busy(busy), .err(err),
    .err_id(err_id), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!s_n) lq <= 1'b1;
    else if (!r_n) lq <= 1'b0;
  end
  assign q_in = stuck ? 1'b0 : lq;

  always @(negedge clk) begin
    if (!s_n && !r_n) viol <= viol + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Assert all requests of mask at once, then follow the round-robin service order.
  task automatic run_round(input logic [N-1:0] mask, input logic [N-1:0] ops);
    logic [N-1:0] pend;
    int g, lat, sl, rl, exp_lat;
    logic pulse, first;
    pend  = mask;
    first = 1'b1;
    @(negedge clk);
    op  = ops;
    req = mask;
    while (pend != '0) begin
      g = -1;
      for (int i = 1; i <= N; i++)
        if (g < 0 && pend[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      pulse   = ((stuck ? 1'b0 : m_q) != ops[g]);
      exp_lat = (pulse ? PW + GW + 3 : 2) + (first ? 0 : 1);
      lat = 0; sl = 0; rl = 0;
      while (ack == '0 && lat < 60) begin
        @(negedge clk);
        lat++;
        if (!s_n) sl++;
        if (!r_n) rl++;
      end
      if (ack == '0) begin
        check_eq("ack_timeout", 0, 1);
        req = '0;
        return;
      end
      check_eq("ack_grant", int'(ack), 1 << g);
      check_eq("ack_latency", lat, exp_lat);
      check_eq("s_n_low_cycles", sl, (pulse && ops[g]) ? PW : 0);
      check_eq("r_n_low_cycles", rl, (pulse && !ops[g]) ? PW : 0);
      if (pulse) begin
        m_q = ops[g];
        if (stuck && ops[g]) begin
          exp_err = 1'b1;
          exp_id  = g;
        end
      end
      check_eq("q_readback", int'(q_in), stuck ? 0 : int'(m_q));
      check_eq("err_flag", int'(err), int'(exp_err));
      if (exp_err) check_eq("err_id", int'(err_id), exp_id);
      m_ptr   = g;
      pend[g] = 1'b0;
      first   = 1'b0;
      @(posedge clk);
      #1;
      req[g] = 1'b0;
    end
  endtask

  initial begin
    int rl, sl, bz, acks, lat;
    logic seen;

    // Reset state and INIT sequence
    repeat (2) @(negedge clk);
    check_eq("rst_s_n", int'(s_n), 1);
    check_eq("rst_r_n", int'(r_n), 1);
    check_eq("rst_ack", int'(ack), 0);
    check_eq("rst_err", int'(err), 0);
    check_eq("rst_err_id", int'(err_id), 0);
    check_eq("rst_busy", int'(busy), 1);
    rst_n = 1'b1;
    rl = 0; bz = -1; acks = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!r_n) rl++;
      if (!busy && bz < 0) bz = k;
      if (ack != '0) acks++;
    end
    check_eq("init_r_n_low", rl, PW);
    check_eq("init_busy_drop", bz, PW + GW);
    check_eq("init_no_ack", acks, 0);
    check_eq("init_q", int'(q_in), 0);

    // Directed rounds
    run_round(4'b0100, 4'b0000);
    run_round(4'b0010, 4'b0010);
    run_round(4'b1011, 4'b1010);
    run_round(4'b0001, 4'b0001);

    // Randomized rounds
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      run_round(4'($urandom_range(15, 1)), 4'($urandom));
    end

    // Latch stuck at 0 while requester 3 sets it
    stuck = 1'b1;
    run_round(4'b1000, 4'b1000);
    stuck = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    check_eq("err_cleared", int'(err), 0);
    check_eq("err_id_kept", int'(err_id), 3);

    // Reset during the second pulse cycle
    run_round(4'b0001, 4'b0000);
    @(negedge clk);
    op  = 4'b0001;
    req = 4'b0001;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (!s_n) seen = 1'b1;
    end
    check_eq("midrst_pulse_seen", int'(seen), 1);
    @(negedge clk);
    check_eq("midrst_second_cycle", int'(s_n), 0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_s_n", int'(s_n), 1);
    check_eq("midrst_r_n", int'(r_n), 1);
    check_eq("midrst_ack", int'(ack), 0);
    check_eq("midrst_busy", int'(busy), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_ptr = N - 1;
    m_q   = 1'b0;
    rl = 0; sl = 0; lat = 0;
    while (ack == '0 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!s_n) sl++;
      if (!r_n) rl++;
    end
    check_eq("replay_ack", int'(ack), 1);
    check_eq("replay_latency", lat, 2 * (PW + GW) + 3);
    check_eq("replay_r_n_low", rl, PW);
    check_eq("replay_s_n_low", sl, PW);
    check_eq("replay_q", int'(q_in), 1);
    @(posedge clk);
    #1;
    req = '0;
    m_ptr = 0;
    m_q   = 1'b1;

    for (int r = 0; r < 4; r++) run_round(4'($urandom_range(15, 1)), 4'($urandom));

    @(negedge clk);
    check_eq("never_both_low", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
